// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and helpers for the shared-register arbiter
//
// Purpose: FSM state type, parameter defaults and the round-robin pointer
// wrap helper, so other register sharers can reuse the same definitions.
// Ports: none (package).
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 15;

  // Next pointer after idx; wraps explicitly so non-power-of-two NREQ works.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_pick.sv
// rtl/shared_reg_arbiter_pick.sv - combinational round-robin priority picker
//
// Purpose: pick the first set request bit searching upward from ptr, wrapping
// from NREQ-1 back to 0.
// Ports:
//   req    in  NREQ          request bits
//   ptr    in  clog2(NREQ)   search start index
//   onehot out NREQ          one-hot winner (zero when no request)
//   idx    out clog2(NREQ)   winner index
//   any    out 1             at least one request set
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         onehot,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (32'(ptr) + 32'(k)) % NREQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = PW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter sharing one register among requesters
//
// Purpose: grants one requester at a time, writes its word into the shared
// register, holds the grant until the request drops, and force-releases a
// requester that holds on for TIMEOUT cycles (sticky err).
// Ports:
//   clk     in  1            clock, rising edge
//   reset   in  1            synchronous active-low reset
//   req     in  NREQ         level requests
//   data    in  NREQ*WIDTH   requester words, requester i at [i*WIDTH +: WIDTH]
//   grant   out NREQ         registered one-hot grant
//   q       out WIDTH        shared register
//   q_owner out clog2(NREQ)  last requester written into q
//   q_valid out 1            q written since reset
//   busy    out 1            FSM not idle
//   err     out 1            sticky watchdog release flag
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        q,
  output logic [$clog2(NREQ)-1:0] q_owner,
  output logic                    q_valid,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NREQ-1:0]   pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          win_d   = pick_idx;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        // Write is committed regardless of the winner's req on this edge.
        q_d     = data[32'(win_q)*WIDTH +: WIDTH];
        owner_d = win_q;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!req[win_q] || cnt_q == CW'(TIMEOUT - 1)) begin
          // Normal and forced release share the same updates; only err differs.
          if (req[win_q]) err_d = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = PW'(rr_next(32'(win_q), NREQ));
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      q_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign q       = q_q;
  assign q_owner = owner_q;
  assign q_valid = valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      q;
  logic [1:0]            q_owner;
  logic                  q_valid;
  logic                  busy;
  logic                  err;

  logic [WIDTH-1:0] data_w [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    data = '0;
    for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = data_w[i];
  end

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .busy    (busy),
    .err     (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected grant/word pushed when a request is driven.
  typedef struct {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] d;
    logic [1:0]       o;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic mon_en  = 1'b0;
  logic pend_q  = 1'b0;
  logic [NREQ-1:0] prev_g = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_q) begin
        chk("sb_q", 32'(q), 32'(cur.d));
        chk("sb_owner", 32'(q_owner), 32'(cur.o));
        chk("sb_valid", 32'(q_valid), 1);
        pend_q = 1'b0;
      end
      if (grant != '0 && prev_g == '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_grant", 32'(grant), 0);
        end else begin
          cur = sb.pop_front();
          chk("sb_grant", 32'(grant), 32'(cur.g));
          chk("sb_busy", 32'(busy), 1);
          pend_q = 1'b1;
        end
      end
      prev_g = grant;
    end
  end

  task automatic push(input int idx);
    exp_t e;
    e.g = NREQ'(1) << idx;
    e.d = data_w[idx];
    e.o = 2'(idx);
    sb.push_back(e);
  endtask

  task automatic wait_on(input string name);
    int n = 0;
    while (grant == '0 && n < 40) begin step(); n++; end
    chk({name, "_arrive"}, 32'(grant != '0), 1);
  endtask

  task automatic wait_off(input string name, output int n);
    n = 0;
    while (grant != '0 && n < 40) begin step(); n++; end
    chk({name, "_release"}, 32'(grant == '0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] d;
    logic [NREQ-1:0]  exp_g;
    logic [1:0]       exp_o;
    int               exp_hold;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int t0;
    vecs[0] = '{2, 8'hA5, 4'b0100, 2'd2, 2};
    vecs[1] = '{0, 8'h3C, 4'b0001, 2'd0, 2};
    vecs[2] = '{3, 8'hFF, 4'b1000, 2'd3, 2};
    vecs[3] = '{1, 8'h00, 4'b0010, 2'd1, 2};
    vecs[4] = '{3, 8'h5A, 4'b1000, 2'd3, 2};

    data_w[0] = 8'h11; data_w[1] = 8'h22; data_w[2] = 8'h33; data_w[3] = 8'h44;

    // Reset with all requests high.
    reset = 1'b0;
    req   = 4'b1111;
    step();
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_owner", 32'(q_owner), 0);
    chk("rst_valid", 32'(q_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    mon_en = 1'b1;
    push(0);
    reset = 1'b1;
    step();
    chk("rst_first_grant", 32'(grant), 32'h1);
    req = 4'b0000;            // dropped during GRANT: write still committed
    wait_off("rst_txn", n);
    chk("rst_txn_hold", 32'(n), 2);

    // Table: single requester transactions.
    for (int i = 0; i < 5; i++) begin
      data_w[vecs[i].idx] = vecs[i].d;
      push(vecs[i].idx);
      req[vecs[i].idx] = 1'b1;
      wait_on("vec");
      chk("vec_grant", 32'(grant), 32'(vecs[i].exp_g));
      req[vecs[i].idx] = 1'b0;
      wait_off("vec", n);
      chk("vec_hold", 32'(n), 32'(vecs[i].exp_hold));
      chk("vec_busy_after", 32'(busy), 0);
      chk("vec_q", 32'(q), 32'(vecs[i].d));
      chk("vec_owner", 32'(q_owner), 32'(vecs[i].exp_o));
    end

    // Fairness: all requesting, order 0,1,2,3,0 at one grant per 3 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) push(i % NREQ);
    req = 4'b1111;
    t0 = -1;
    for (int i = 0; i < 5; i++) begin
      wait_on("fair");
      chk("fair_order", 32'(grant), 32'(NREQ'(1) << (i % NREQ)));
      if (t0 >= 0) chk("fair_spacing", 32'(cyc - t0), 3);
      t0 = cyc;
      if (i == 4) req = 4'b0000;
      else        req[i % NREQ] = 1'b0;
      wait_off("fair", n);
      if (i < 4) req[i % NREQ] = 1'b1;
    end

    // Move ptr to 2, then bits 1 and 3 together: 3 wins, then 1.
    push(1);
    req[1] = 1'b1;
    wait_on("ptr2");
    req[1] = 1'b0;
    wait_off("ptr2", n);
    push(3);
    push(1);
    req = 4'b1010;
    wait_on("sim_a");
    chk("sim_first", 32'(grant), 32'h8);
    req[3] = 1'b0;
    wait_off("sim_a", n);
    wait_on("sim_b");
    chk("sim_second", 32'(grant), 32'h2);
    req = 4'b0000;
    wait_off("sim_b", n);

    // Watchdog: req[0] held, forced release after TIMEOUT WAIT cycles.
    data_w[0] = 8'hC3;
    push(0);
    req = 4'b0001;
    wait_on("wd");
    chk("wd_err_before", 32'(err), 0);
    wait_off("wd", n);
    chk("wd_hold", 32'(n), 32'(TIMEOUT + 1));
    chk("wd_err", 32'(err), 1);
    chk("wd_q", 32'(q), 32'hC3);
    chk("wd_owner", 32'(q_owner), 0);
    // ptr is now 1, so requester 3 beats the still-requesting 0.
    push(3);
    req = 4'b1001;
    wait_on("wd_next");
    chk("wd_ptr_next", 32'(grant), 32'h8);
    req = 4'b0000;
    wait_off("wd_next", n);
    chk("wd_err_sticky", 32'(err), 1);

    // Reset during WAIT.
    data_w[2] = 8'h77;
    push(2);
    req = 4'b0100;
    wait_on("rw");
    step();
    step();
    chk("rw_q_before", 32'(q), 32'h77);
    reset = 1'b0;
    step();
    chk("rw_grant", 32'(grant), 0);
    chk("rw_q", 32'(q), 0);
    chk("rw_valid", 32'(q_valid), 0);
    chk("rw_err", 32'(err), 0);
    chk("rw_busy", 32'(busy), 0);
    reset = 1'b1;
    req   = 4'b0000;
    step();
    step();
    chk("rw_idle_grant", 32'(grant), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
